// File: rtl/timer_bank_pkg.sv
// rtl/timer_bank_pkg.sv - shared encodings for the timer bank
//
// Purpose : count-mode and channel FSM state encodings, plus a small
//           mode decode helper, shared by timer_bank and timer_bank_ch.
// Ports   : none (package).
package timer_bank_pkg;

    localparam logic [1:0] MODE_UP     = 2'd0;
    localparam logic [1:0] MODE_DOWN   = 2'd1;
    localparam logic [1:0] MODE_UPDOWN = 2'd2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Down mode is the only mode whose load value is top rather than 0;
    // the reserved encoding behaves as up.
    function automatic logic mode_is_down(input logic [1:0] mode);
        return (mode == MODE_DOWN);
    endfunction

endpackage

// File: rtl/timer_bank_if.sv
// rtl/timer_bank_if.sv - register-side bundle of the timer bank
//
// Purpose : groups every per-channel control input and status output of
//           timer_bank. master = software register side, slave = timer.
// Signals : top, presc, mode, freerun, start, stop, clr_it  (to timer)
//           cnt, running, ovf, it, irq                      (from timer)
//           cmp / cmp_hit, pwm only with TIMER_BANK_CMP_EN defined.
interface timer_bank_if #(
    parameter int NCH = 4,
    parameter int W   = 16,
    parameter int PW  = 8
);
    logic [NCH*W-1:0]  top;
    logic [NCH*PW-1:0] presc;
    logic [NCH*2-1:0]  mode;
    logic [NCH-1:0]    freerun;
    logic [NCH-1:0]    start;
    logic [NCH-1:0]    stop;
    logic [NCH-1:0]    clr_it;
    logic [NCH*W-1:0]  cnt;
    logic [NCH-1:0]    running;
    logic [NCH-1:0]    ovf;
    logic [NCH-1:0]    it;
    logic              irq;
`ifdef TIMER_BANK_CMP_EN
    logic [NCH*W-1:0]  cmp;
    logic [NCH-1:0]    cmp_hit;
    logic [NCH-1:0]    pwm;
`endif

    modport master (
`ifdef TIMER_BANK_CMP_EN
        output cmp,
        input  cmp_hit, pwm,
`endif
        output top, presc, mode, freerun, start, stop, clr_it,
        input  cnt, running, ovf, it, irq
    );

    modport slave (
`ifdef TIMER_BANK_CMP_EN
        input  cmp,
        output cmp_hit, pwm,
`endif
        input  top, presc, mode, freerun, start, stop, clr_it,
        output cnt, running, ovf, it, irq
    );

endinterface

// File: rtl/timer_bank_ch.sv
// rtl/timer_bank_ch.sv - one timer channel
//
// Purpose : prescaler, IDLE/RUN FSM, up/down/up-down counter, registered
//           terminal pulse and sticky interrupt flag for a single channel.
// Ports   : clk, rstn (async, active-low)
//           i_top, i_presc, i_mode, i_freerun, i_start, i_stop, i_clr_it
//           o_cnt, o_running, o_ovf, o_it
//           i_cmp, o_cmp_hit, o_pwm when TIMER_BANK_CMP_EN is defined.
module timer_bank_ch
    import timer_bank_pkg::*;
#(
    parameter int W  = 16,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [W-1:0]  i_top,
    input  logic [PW-1:0] i_presc,
    input  logic [1:0]    i_mode,
    input  logic          i_freerun,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_clr_it,
`ifdef TIMER_BANK_CMP_EN
    input  logic [W-1:0]  i_cmp,
    output logic          o_cmp_hit,
    output logic          o_pwm,
`endif
    output logic [W-1:0]  o_cnt,
    output logic          o_running,
    output logic          o_ovf,
    output logic          o_it
);

    logic [0:0]    r_state;
    logic [W-1:0]  r_cnt;
    logic [PW-1:0] r_pre;
    logic          r_dir_dn;
    logic          r_ovf;
    logic          r_it;

    logic [W-1:0]  w_load;
    logic          w_run;
    logic          w_tick;
    logic [W-1:0]  w_cnt_nx;
    logic          w_dir_nx;
    logic          w_term;
    logic          w_event;

    assign w_load = mode_is_down(i_mode) ? i_top : '0;
    assign w_run  = (r_state == ST_RUN);
    // >= rather than == so a prescale lowered below the running phase
    // still ticks on the next clock instead of wrapping the prescaler.
    assign w_tick = w_run && (r_pre >= i_presc);

    always_comb begin
        w_cnt_nx = r_cnt;
        w_dir_nx = r_dir_dn;
        w_term   = 1'b0;
        case (i_mode)
            MODE_DOWN: begin
                if (r_cnt == '0) begin
                    w_cnt_nx = i_top;
                    w_term   = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - W'(1);
                end
            end
            MODE_UPDOWN: begin
                if (!r_dir_dn) begin
                    if (r_cnt >= i_top) begin
                        // Turning point; with top<=1 the step down already
                        // lands on 0, which is the terminal event itself.
                        if (i_top <= W'(1)) begin
                            w_cnt_nx = '0;
                            w_term   = 1'b1;
                        end else begin
                            w_cnt_nx = i_top - W'(1);
                            w_dir_nx = 1'b1;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + W'(1);
                    end
                end else begin
                    if (r_cnt <= W'(1)) begin
                        w_cnt_nx = '0;
                        w_dir_nx = 1'b0;
                        w_term   = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt - W'(1);
                    end
                end
            end
            default: begin
                // >= keeps a channel from running away when top drops
                // below the current count mid-run.
                if (r_cnt >= i_top) begin
                    w_cnt_nx = '0;
                    w_term   = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + W'(1);
                end
            end
        endcase
    end

    // start/stop on the same edge pre-empt any terminal event.
    assign w_event = w_tick && w_term && !i_start && !i_stop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_pre    <= '0;
            r_dir_dn <= 1'b0;
            r_ovf    <= 1'b0;
            r_it     <= 1'b0;
        end else begin
            r_ovf <= w_event;
            r_it  <= w_event | (r_it & ~i_clr_it);
            if (i_stop) begin
                r_state  <= ST_IDLE;
                r_pre    <= '0;
                r_dir_dn <= 1'b0;
            end else if (i_start) begin
                r_state  <= ST_RUN;
                r_cnt    <= w_load;
                r_pre    <= '0;
                r_dir_dn <= 1'b0;
            end else if (w_run) begin
                if (w_tick) begin
                    r_pre <= '0;
                    if (w_term && !i_freerun) begin
                        r_state  <= ST_IDLE;
                        r_dir_dn <= 1'b0;
                    end else begin
                        r_cnt    <= w_cnt_nx;
                        r_dir_dn <= w_dir_nx;
                    end
                end else begin
                    r_pre <= r_pre + PW'(1);
                end
            end
        end
    end

    // While idle the visible count is the load value of the current mode,
    // so reset, stop and one-shot completion all present load without
    // needing an asynchronous load of a live input.
    assign o_cnt     = w_run ? r_cnt : w_load;
    assign o_running = w_run;
    assign o_ovf     = r_ovf;
    assign o_it      = r_it;

`ifdef TIMER_BANK_CMP_EN
    logic r_cmp_hit;
    logic w_count_en;

    assign w_count_en = w_tick && !i_start && !i_stop && !(w_term && !i_freerun);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cmp_hit <= 1'b0;
        end else begin
            r_cmp_hit <= w_count_en && (w_cnt_nx == i_cmp) && (r_cnt != i_cmp);
        end
    end

    assign o_cmp_hit = r_cmp_hit;
    assign o_pwm     = w_run && (mode_is_down(i_mode) ? (r_cnt >= i_cmp) : (r_cnt < i_cmp));
`endif

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - multi-channel system timer
//
// Purpose : NCH independent timer channels plus a registered OR of their
//           sticky interrupt flags for the interrupt controller.
// Ports   : clk, rstn (async, active-low)
//           bus : timer_bank_if.slave (per-channel controls and status, irq)
// Option  : TIMER_BANK_CMP_EN adds per-channel compare (cmp, cmp_hit, pwm).
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 16,
    parameter int PW  = 8
) (
    input  logic        clk,
    input  logic        rstn,
    timer_bank_if.slave bus
);

    logic [NCH*W-1:0] w_cnt;
    logic [NCH-1:0]   w_running;
    logic [NCH-1:0]   w_ovf;
    logic [NCH-1:0]   w_it;
    logic             r_irq;
`ifdef TIMER_BANK_CMP_EN
    logic [NCH-1:0]   w_cmp_hit;
    logic [NCH-1:0]   w_pwm;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        timer_bank_ch #(
            .W  (W),
            .PW (PW)
        ) u_ch (
            .clk       (clk),
            .rstn      (rstn),
            .i_top     (bus.top[i*W +: W]),
            .i_presc   (bus.presc[i*PW +: PW]),
            .i_mode    (bus.mode[i*2 +: 2]),
            .i_freerun (bus.freerun[i]),
            .i_start   (bus.start[i]),
            .i_stop    (bus.stop[i]),
            .i_clr_it  (bus.clr_it[i]),
`ifdef TIMER_BANK_CMP_EN
            .i_cmp     (bus.cmp[i*W +: W]),
            .o_cmp_hit (w_cmp_hit[i]),
            .o_pwm     (w_pwm[i]),
`endif
            .o_cnt     (w_cnt[i*W +: W]),
            .o_running (w_running[i]),
            .o_ovf     (w_ovf[i]),
            .o_it      (w_it[i])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_it;
        end
    end

    assign bus.cnt     = w_cnt;
    assign bus.running = w_running;
    assign bus.ovf     = w_ovf;
    assign bus.it      = w_it;
    assign bus.irq     = r_irq;
`ifdef TIMER_BANK_CMP_EN
    assign bus.cmp_hit = w_cmp_hit;
    assign bus.pwm     = w_pwm;
`endif

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - self-checking bench for timer_bank
module tb_timer_bank;

    localparam int NCH = 4;
    localparam int W   = 16;
    localparam int PW  = 8;

    logic clk;
    logic rstn;

    timer_bank_if #(.NCH(NCH), .W(W), .PW(PW)) bus ();

    timer_bank #(.NCH(NCH), .W(W), .PW(PW)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus as plain per-channel arrays, packed onto the bus.
    int t_top[NCH], t_presc[NCH], t_mode[NCH], t_cmp[NCH];
    bit t_freerun[NCH], t_start[NCH], t_stop[NCH], t_clr[NCH];

    always_comb begin
        bus.top     = '0;
        bus.presc   = '0;
        bus.mode    = '0;
        bus.freerun = '0;
        bus.start   = '0;
        bus.stop    = '0;
        bus.clr_it  = '0;
`ifdef TIMER_BANK_CMP_EN
        bus.cmp     = '0;
`endif
        for (int i = 0; i < NCH; i++) begin
            bus.top[i*W +: W]    = W'(t_top[i]);
            bus.presc[i*PW +: PW] = PW'(t_presc[i]);
            bus.mode[i*2 +: 2]   = 2'(t_mode[i]);
            bus.freerun[i]       = t_freerun[i];
            bus.start[i]         = t_start[i];
            bus.stop[i]          = t_stop[i];
            bus.clr_it[i]        = t_clr[i];
`ifdef TIMER_BANK_CMP_EN
            bus.cmp[i*W +: W]    = W'(t_cmp[i]);
`endif
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each channel is a running flag, a count, a tick
    // phase counter and a direction, advanced by the counting rules.
    int m_cnt[NCH], m_pre[NCH];
    bit m_run[NCH], m_dn[NCH], m_ovf[NCH], m_it[NCH], m_hit[NCH];
    bit m_irq;

    function automatic int load_of(int i);
        return (t_mode[i] == 1) ? t_top[i] : 0;
    endfunction

    function automatic int exp_cnt(int i);
        return m_run[i] ? m_cnt[i] : load_of(i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_run[i] = 0; m_dn[i] = 0;
            m_ovf[i] = 0; m_it[i] = 0; m_hit[i] = 0;
        end
        m_irq = 0;
    endtask

    task automatic model_step();
        bit any_it;
        if (!rstn) begin
            model_reset();
            return;
        end
        any_it = 0;
        for (int i = 0; i < NCH; i++) any_it |= m_it[i];
        for (int i = 0; i < NCH; i++) begin
            int nxt;
            int top;
            bit ev;
            bit hit;
            ev = 0; hit = 0; top = t_top[i]; nxt = m_cnt[i];
            if (t_stop[i]) begin
                m_run[i] = 0; m_pre[i] = 0; m_dn[i] = 0;
            end else if (t_start[i]) begin
                m_run[i] = 1; m_cnt[i] = load_of(i); m_pre[i] = 0; m_dn[i] = 0;
            end else if (m_run[i]) begin
                if (m_pre[i] < t_presc[i]) begin
                    m_pre[i]++;
                end else begin
                    m_pre[i] = 0;
                    if (t_mode[i] == 1) begin
                        if (m_cnt[i] == 0) begin nxt = top; ev = 1; end
                        else nxt = m_cnt[i] - 1;
                    end else if (t_mode[i] == 2) begin
                        if (m_dn[i]) begin
                            nxt = m_cnt[i] - 1;
                            if (nxt <= 0) begin nxt = 0; ev = 1; m_dn[i] = 0; end
                        end else if (m_cnt[i] < top) begin
                            nxt = m_cnt[i] + 1;
                        end else begin
                            nxt = top - 1;
                            if (nxt <= 0) begin nxt = 0; ev = 1; end
                            else m_dn[i] = 1;
                        end
                    end else begin
                        if (m_cnt[i] >= top) begin nxt = 0; ev = 1; end
                        else nxt = m_cnt[i] + 1;
                    end
                    if (ev && !t_freerun[i]) begin
                        m_run[i] = 0; m_dn[i] = 0;
                    end else begin
                        hit = (nxt == t_cmp[i]) && (m_cnt[i] != t_cmp[i]);
                        m_cnt[i] = nxt;
                    end
                end
            end
            m_ovf[i] = ev;
            m_it[i]  = ev | (m_it[i] & !t_clr[i]);
            m_hit[i] = hit;
        end
        m_irq = any_it;
    endtask

    task automatic compare_all();
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("cnt%0d", i), 32'(bus.cnt[i*W +: W]), 32'(exp_cnt(i)));
            chk($sformatf("running%0d", i), 32'(bus.running[i]), 32'(m_run[i]));
            chk($sformatf("ovf%0d", i), 32'(bus.ovf[i]), 32'(m_ovf[i]));
            chk($sformatf("it%0d", i), 32'(bus.it[i]), 32'(m_it[i]));
`ifdef TIMER_BANK_CMP_EN
            chk($sformatf("cmp_hit%0d", i), 32'(bus.cmp_hit[i]), 32'(m_hit[i]));
            chk($sformatf("pwm%0d", i), 32'(bus.pwm[i]),
                32'(m_run[i] && ((t_mode[i] == 1) ? (m_cnt[i] >= t_cmp[i]) : (m_cnt[i] < t_cmp[i]))));
`endif
        end
        chk("irq", 32'(bus.irq), 32'(m_irq));
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] dcnt(int i);
        return 32'(bus.cnt[i*W +: W]);
    endfunction

    initial begin
        int dn_tbl[8];
        int ud_tbl[13];
        dn_tbl = '{3, 3, 2, 2, 1, 1, 0, 0};
        ud_tbl = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};

        rstn = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            t_top[i] = 4; t_presc[i] = 0; t_mode[i] = 0; t_cmp[i] = 3;
            t_freerun[i] = 1; t_start[i] = 0; t_stop[i] = 0; t_clr[i] = 0;
        end
        t_mode[1] = 1; t_top[1] = 3; t_presc[1] = 1; t_freerun[1] = 0;
        t_mode[2] = 2; t_top[2] = 3;
        t_top[3] = 9;
        model_reset();
        #2;
        compare_all();
        chk("rst_cnt1_load", dcnt(1), 3);
        chk("rst_irq", 32'(bus.irq), 0);
        @(posedge clk);
        #3 rstn = 1'b1;

        // Up free-run, top=4
        t_start[0] = 1; tick_cycle(); t_start[0] = 0;
        chk("up_seq0", dcnt(0), 0);
        for (int k = 1; k <= 10; k++) begin
            tick_cycle();
            chk($sformatf("up_seq%0d", k), dcnt(0), 32'(k % 5));
            chk($sformatf("up_ovf%0d", k), 32'(bus.ovf[0]), 32'(k % 5 == 0));
        end
        chk("up_it_held", 32'(bus.it[0]), 1);

        // Down one-shot, top=3, presc=1
        t_start[1] = 1; tick_cycle(); t_start[1] = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick_cycle();
            chk($sformatf("dn_seq%0d", k), dcnt(1), 32'(dn_tbl[k]));
        end
        tick_cycle();
        chk("dn_ovf", 32'(bus.ovf[1]), 1);
        chk("dn_running", 32'(bus.running[1]), 0);
        for (int k = 0; k < 4; k++) begin
            tick_cycle();
            chk("dn_no_ovf", 32'(bus.ovf[1]), 0);
        end

        // Up-down, top=3
        t_start[2] = 1; tick_cycle(); t_start[2] = 0;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) tick_cycle();
            chk($sformatf("ud_seq%0d", k), dcnt(2), 32'(ud_tbl[k]));
            chk($sformatf("ud_ovf%0d", k), 32'(bus.ovf[2]), 32'(k == 6 || k == 12));
        end

        // top lowered 8 -> 2 at cnt=5, then clr_it against a terminal event
        t_top[0] = 8; t_start[0] = 1; tick_cycle(); t_start[0] = 0;
        for (int k = 0; k < 5; k++) tick_cycle();
        chk("lower_pre", dcnt(0), 5);
        t_top[0] = 2; tick_cycle();
        chk("lower_wrap", dcnt(0), 0);
        chk("lower_ovf", 32'(bus.ovf[0]), 1);
        t_clr[0] = 1; tick_cycle(); t_clr[0] = 0;
        chk("clr_it", 32'(bus.it[0]), 0);
        tick_cycle();
        t_clr[0] = 1; tick_cycle(); t_clr[0] = 0;
        chk("clr_vs_set_ovf", 32'(bus.ovf[0]), 1);
        chk("clr_vs_set_it", 32'(bus.it[0]), 1);

        // start and stop together
        t_start[3] = 1; t_stop[3] = 1; tick_cycle(); t_start[3] = 0; t_stop[3] = 0;
        chk("start_stop", 32'(bus.running[3]), 0);

        // async reset mid-run at cnt=7
        t_top[0] = 20; t_start[0] = 1; tick_cycle(); t_start[0] = 0;
        for (int k = 0; k < 7; k++) tick_cycle();
        chk("rst_pre_cnt", dcnt(0), 7);
        #2 rstn = 1'b0;
        model_reset();
        #1;
        chk("rst_async_cnt", dcnt(0), 0);
        chk("rst_async_run", 32'(bus.running[0]), 0);
        chk("rst_async_it", 32'(bus.it[0]), 0);
        chk("rst_async_irq", 32'(bus.irq), 0);
        tick_cycle();
        tick_cycle();
        #2 rstn = 1'b1;
        for (int k = 0; k < 5; k++) tick_cycle();
        chk("post_rst_idle", 32'(bus.running[0]), 0);
        chk("post_rst_cnt", dcnt(0), 0);

        // Randomized traffic against the model
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < NCH; i++) begin
                t_start[i] = ($urandom_range(0, 39) == 0);
                t_stop[i]  = ($urandom_range(0, 119) == 0);
                t_clr[i]   = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 59) == 0)  t_top[i] = $urandom_range(0, 9);
                if ($urandom_range(0, 79) == 0)  t_presc[i] = $urandom_range(0, 2);
                if ($urandom_range(0, 149) == 0) t_mode[i] = $urandom_range(0, 3);
                if ($urandom_range(0, 99) == 0)  t_freerun[i] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 99) == 0)  t_cmp[i] = $urandom_range(0, 9);
            end
            tick_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
